// File: rtl/ctrl_scheduler.sv
// ctrl_scheduler: in-order operation FIFO with per-channel drain windows,
// a registered fetch stream and a fixed-latency commit pipe.
module ctrl_scheduler #(
    parameter int  FETCH_W    = 32,
    parameter int  COMMIT_W   = 16,
    parameter int  N_CH       = 2,
    parameter int  T_D        = 4,
    parameter int  COMMIT_LAT = T_D + 1,
    parameter int  DEPTH      = 4,
    parameter int  STRICT     = 0,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_drain_i,
    input  logic [CH_W-1:0]     in_ch_i,
    input  logic [FETCH_W-1:0]  in_fetch_i,
    input  logic [COMMIT_W-1:0] in_commit_i,
    input  logic                flush_i,
    output logic                fetch_valid_o,
    output logic [CH_W-1:0]     fetch_ch_o,
    output logic [FETCH_W-1:0]  fetch_o,
    output logic                commit_valid_o,
    output logic [COMMIT_W-1:0] commit_o,
    output logic [N_CH-1:0]     drain_busy_o,
    output logic [LW-1:0]       level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(T_D + 1);
    localparam int NP = 1 << CH_W;

    typedef struct packed {
        logic                drain;
        logic [CH_W-1:0]     ch;
        logic [FETCH_W-1:0]  fetch;
        logic [COMMIT_W-1:0] commit;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [LW-1:0]         level_q, level_d;
    logic [TW-1:0]         cnt_q [N_CH];
    logic                  fv_q;
    logic [CH_W-1:0]       fch_q;
    logic [FETCH_W-1:0]    fd_q;
    logic [COMMIT_LAT-1:0] pv_q;
    logic [COMMIT_W-1:0]   pd_q [COMMIT_LAT];

    entry_t                head;
    logic [NP-1:0]         busy_pad;
    logic                  push;
    logic                  blocked;
    logic                  issue;

    assign head       = mem_q[rd_q];
    assign in_ready_o = (level_q != LW'(DEPTH)) && !flush_i;
    assign push       = in_valid_i && in_ready_o;

    // Padded so any encodable channel index is a legal lookup.
    always_comb begin
        busy_pad = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy_pad[i] = (cnt_q[i] != '0);
        end
    end

    assign drain_busy_o = busy_pad[N_CH-1:0];
    assign blocked = (head.drain || (STRICT != 0)) && busy_pad[head.ch];
    assign issue   = (level_q != '0) && !blocked && !flush_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q + LW'(push) - LW'(issue);
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (issue) begin
            rd_d = rd_q + PW'(1);
        end
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wr_q] <= {in_drain_i, in_ch_i, in_fetch_i, in_commit_i};
            end
        end
    end

    // A drain issue reloads its window; the load wins over the decrement.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            fv_q  <= 1'b0;
            fch_q <= '0;
            fd_q  <= '0;
            pv_q  <= '0;
            for (int k = 0; k < COMMIT_LAT; k++) begin
                pd_q[k] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (issue && head.drain && (head.ch == CH_W'(i))) begin
                    cnt_q[i] <= TW'(T_D);
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - TW'(1);
                end
            end
            fv_q <= issue;
            if (issue) begin
                fch_q <= head.ch;
                fd_q  <= head.fetch;
            end
            pv_q[0] <= issue;
            pd_q[0] <= issue ? head.commit : '0;
            for (int k = 1; k < COMMIT_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pd_q[k] <= pd_q[k-1];
            end
        end
    end

    assign fetch_valid_o  = fv_q;
    assign fetch_ch_o     = fch_q;
    assign fetch_o        = fd_q;
    assign commit_valid_o = pv_q[COMMIT_LAT-1];
    assign commit_o       = pd_q[COMMIT_LAT-1];
    assign level_o        = level_q;

endmodule

// File: tb/tb_ctrl_scheduler.sv
// tb_ctrl_scheduler: directed scenarios and randomized traffic compared
// cycle by cycle with a transaction-level model of the scheduler.
module tb_ctrl_scheduler;
    localparam int FETCH_W    = 32;
    localparam int COMMIT_W   = 16;
    localparam int N_CH       = 2;
    localparam int T_D        = 4;
    localparam int COMMIT_LAT = 5;
    localparam int DEPTH      = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                rst_i = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_drain_i = 1'b0;
    logic [0:0]          in_ch_i = '0;
    logic [FETCH_W-1:0]  in_fetch_i = '0;
    logic [COMMIT_W-1:0] in_commit_i = '0;
    logic                flush_i = 1'b0;
    logic                in_ready_o;
    logic                fetch_valid_o;
    logic [0:0]          fetch_ch_o;
    logic [FETCH_W-1:0]  fetch_o;
    logic                commit_valid_o;
    logic [COMMIT_W-1:0] commit_o;
    logic [N_CH-1:0]     drain_busy_o;
    logic [2:0]          level_o;

    logic                s_valid = 1'b0;
    logic                s_drain = 1'b0;
    logic [0:0]          s_ch = '0;
    logic                s_ready;
    logic                s_fv;
    logic [0:0]          s_fch;
    logic [FETCH_W-1:0]  s_fetch;
    logic                s_cv;
    logic [COMMIT_W-1:0] s_commit;
    logic [N_CH-1:0]     s_busy;
    logic [2:0]          s_level;

    ctrl_scheduler #(
        .FETCH_W(FETCH_W), .COMMIT_W(COMMIT_W), .N_CH(N_CH), .T_D(T_D),
        .COMMIT_LAT(COMMIT_LAT), .DEPTH(DEPTH), .STRICT(0)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_drain_i(in_drain_i), .in_ch_i(in_ch_i),
        .in_fetch_i(in_fetch_i), .in_commit_i(in_commit_i),
        .flush_i(flush_i),
        .fetch_valid_o(fetch_valid_o), .fetch_ch_o(fetch_ch_o),
        .fetch_o(fetch_o),
        .commit_valid_o(commit_valid_o), .commit_o(commit_o),
        .drain_busy_o(drain_busy_o), .level_o(level_o)
    );

    ctrl_scheduler #(
        .FETCH_W(FETCH_W), .COMMIT_W(COMMIT_W), .N_CH(N_CH), .T_D(T_D),
        .COMMIT_LAT(COMMIT_LAT), .DEPTH(DEPTH), .STRICT(1)
    ) u_strict (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(s_valid), .in_ready_o(s_ready),
        .in_drain_i(s_drain), .in_ch_i(s_ch),
        .in_fetch_i(in_fetch_i), .in_commit_i(in_commit_i),
        .flush_i(1'b0),
        .fetch_valid_o(s_fv), .fetch_ch_o(s_fch), .fetch_o(s_fetch),
        .commit_valid_o(s_cv), .commit_o(s_commit),
        .drain_busy_o(s_busy), .level_o(s_level)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: op queue, per-channel "free from cycle" stamps, and
    // expected output events keyed by cycle number.
    typedef struct {
        bit                  drain;
        int                  ch;
        logic [FETCH_W-1:0]  f;
        logic [COMMIT_W-1:0] c;
    } op_t;

    op_t                 q[$];
    int                  free_at [N_CH];
    op_t                 fexp [int];
    logic [COMMIT_W-1:0] cexp [int];
    int                  now = 0;

    int                  fv_cyc[$];
    logic [FETCH_W-1:0]  fv_val[$];
    int                  cm_cyc[$];
    logic [COMMIT_W-1:0] cm_val[$];
    int                  sfv_cyc[$];
    int                  busy0_cyc[$];
    bit                  saw_both;
    bit                  rdy_low;
    int                  max_level;

    task automatic model_reset();
        q.delete();
        fexp.delete();
        cexp.delete();
        for (int c = 0; c < N_CH; c++) free_at[c] = 0;
    endtask

    task automatic cyc(input bit v, input bit d, input int ch,
                       input logic [FETCH_W-1:0] f,
                       input logic [COMMIT_W-1:0] c, input bit fl,
                       output bit acc);
        bit  rdy;
        bit  iss;
        op_t h;
        in_valid_i  = v;
        in_drain_i  = d;
        in_ch_i     = 1'(ch);
        in_fetch_i  = f;
        in_commit_i = c;
        flush_i     = fl;
        #1;
        rdy = (q.size() != DEPTH) && !fl;
        chk("in_ready", in_ready_o, rdy);
        if (!in_ready_o) rdy_low = 1;
        acc = v && in_ready_o;
        iss = 0;
        if (!fl && q.size() > 0) begin
            iss = !(q[0].drain && (now < free_at[q[0].ch]));
        end
        if (iss) begin
            h = q.pop_front();
            fexp[now + 1] = h;
            cexp[now + COMMIT_LAT] = h.c;
            if (h.drain) free_at[h.ch] = now + T_D + 1;
        end
        if (fl) q.delete();
        if (v && rdy) q.push_back('{drain: d, ch: ch, f: f, c: c});
        @(posedge clk_i);
        #1;
        now++;
        chk("level", level_o, q.size());
        for (int k = 0; k < N_CH; k++) begin
            chk("drain_busy", drain_busy_o[k], now < free_at[k]);
        end
        chk("fetch_valid", fetch_valid_o, fexp.exists(now));
        if (fexp.exists(now)) begin
            chk("fetch_ch", fetch_ch_o, fexp[now].ch);
            chk("fetch", fetch_o, fexp[now].f);
            fexp.delete(now);
        end
        chk("commit_valid", commit_valid_o, cexp.exists(now));
        chk("commit", commit_o, cexp.exists(now) ? cexp[now] : '0);
        if (cexp.exists(now)) cexp.delete(now);
        if (fetch_valid_o) begin
            fv_cyc.push_back(now);
            fv_val.push_back(fetch_o);
        end
        if (commit_valid_o) begin
            cm_cyc.push_back(now);
            cm_val.push_back(commit_o);
        end
        if (s_fv) sfv_cyc.push_back(now);
        if (drain_busy_o[0]) busy0_cyc.push_back(now);
        if (drain_busy_o == 2'b11) saw_both = 1;
        if (int'(level_o) > max_level) max_level = int'(level_o);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) cyc(0, 0, 0, '0, '0, 0, a);
    endtask

    task automatic clear_mon();
        fv_cyc.delete();
        fv_val.delete();
        cm_cyc.delete();
        cm_val.delete();
        sfv_cyc.delete();
        busy0_cyc.delete();
        saw_both  = 0;
        rdy_low   = 0;
        max_level = 0;
    endtask

    initial begin
        bit a;
        bit acc[8];
        int t0;
        int nb;
        logic [FETCH_W-1:0] exp4 [6];

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_level", level_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_busy", drain_busy_o, 0);
        chk("rst_fv", fetch_valid_o, 0);
        chk("rst_fch", fetch_ch_o, 0);
        chk("rst_fetch", fetch_o, 0);
        chk("rst_cv", commit_valid_o, 0);
        chk("rst_commit", commit_o, 0);
        chk("rst_strict", {s_level, s_busy, s_fv, s_fch, s_cv, s_ready},
            {3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_strict_data", {s_fetch, s_commit}, '0);
        rst_i = 1'b1;
        model_reset();

        // Four plain ops back to back.
        clear_mon();
        t0 = now;
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, i, i, 0, a);
        idle(10);
        chk("t1_nfetch", fv_cyc.size(), 4);
        if (fv_cyc.size() == 4) begin
            chk("t1_first_fetch", fv_cyc[0] - t0, 2);
            chk("t1_consec", fv_cyc[3] - fv_cyc[0], 3);
        end
        chk("t1_ncommit", cm_val.size(), 4);
        if (cm_val.size() == 4) begin
            chk("t1_commit_lat", cm_cyc[0] - t0, 1 + COMMIT_LAT);
            for (int i = 0; i < 4; i++) chk("t1_commit_val", cm_val[i], i + 1);
        end
        chk("t1_peak_level", max_level, 1);

        // Two drains on channel 0.
        clear_mon();
        cyc(1, 1, 0, 'h21, 'h21, 0, a);
        cyc(1, 1, 0, 'h22, 'h22, 0, a);
        idle(12);
        chk("t2_nfetch", fv_cyc.size(), 2);
        if (fv_cyc.size() == 2) begin
            chk("t2_gap", fv_cyc[1] - fv_cyc[0], T_D + 1);
            nb = 0;
            foreach (busy0_cyc[i]) begin
                if (busy0_cyc[i] >= fv_cyc[0] && busy0_cyc[i] < fv_cyc[1]) nb++;
            end
            chk("t2_busy_cycles", nb, T_D);
        end
        chk("t2_ready_low", rdy_low, 0);

        // Drain ch0 then drain ch1.
        clear_mon();
        cyc(1, 1, 0, 'h31, 'h31, 0, a);
        cyc(1, 1, 1, 'h32, 'h32, 0, a);
        idle(8);
        chk("t3_nfetch", fv_cyc.size(), 2);
        if (fv_cyc.size() == 2) chk("t3_gap", fv_cyc[1] - fv_cyc[0], 1);
        chk("t3_overlap", saw_both, 1);

        // Drain ch0 then plain ch0, relaxed and strict instances.
        clear_mon();
        s_valid = 1'b1;
        s_drain = 1'b1;
        s_ch    = 1'b0;
        cyc(1, 1, 0, 'h33, 'h33, 0, a);
        s_drain = 1'b0;
        cyc(1, 0, 0, 'h34, 'h34, 0, a);
        s_valid = 1'b0;
        idle(10);
        chk("t3b_nfetch", fv_cyc.size(), 2);
        if (fv_cyc.size() == 2) chk("t3b_gap", fv_cyc[1] - fv_cyc[0], 1);
        chk("t3b_strict_nfetch", sfv_cyc.size(), 2);
        if (sfv_cyc.size() == 2) begin
            chk("t3b_strict_gap", sfv_cyc[1] - sfv_cyc[0], 1 + T_D);
        end

        // Blocked head, fill to full, push while full and popping.
        clear_mon();
        cyc(1, 1, 0, 'h40, 'h40, 0, acc[0]);
        cyc(1, 1, 0, 'h41, 'h41, 0, acc[1]);
        cyc(1, 0, 1, 'h42, 'h42, 0, acc[2]);
        cyc(1, 0, 1, 'h43, 'h43, 0, acc[3]);
        cyc(1, 0, 1, 'h44, 'h44, 0, acc[4]);
        chk("t4_full_level", level_o, 4);
        cyc(1, 0, 1, 'h45, 'h45, 0, acc[5]);
        cyc(1, 0, 1, 'h46, 'h46, 0, acc[6]);
        cyc(1, 0, 1, 'h47, 'h47, 0, acc[7]);
        chk("t4_acc_last_fill", acc[4], 1);
        chk("t4_acc_full", acc[5], 0);
        chk("t4_acc_full_pop", acc[6], 0);
        chk("t4_acc_after", acc[7], 1);
        idle(12);
        exp4 = '{'h40, 'h41, 'h42, 'h43, 'h44, 'h47};
        chk("t4_nfetch", fv_val.size(), 6);
        if (fv_val.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t4_order", fv_val[i], exp4[i]);
        end

        // Flush with three queued and two commits in flight.
        cyc(1, 0, 1, 'h51, 'h51, 0, a);
        cyc(1, 1, 0, 'h52, 'h52, 0, a);
        cyc(1, 1, 0, 'h53, 'h53, 0, a);
        cyc(1, 0, 1, 'h54, 'h54, 0, a);
        cyc(1, 0, 1, 'h55, 'h55, 0, a);
        chk("t5_queued", level_o, 3);
        clear_mon();
        cyc(1, 0, 1, 'h56, 'h56, 1, acc[0]);
        chk("t5_push_refused", acc[0], 0);
        chk("t5_level_zero", level_o, 0);
        idle(8);
        chk("t5_ncommit", cm_val.size(), 2);
        if (cm_val.size() == 2) begin
            chk("t5_commit0", cm_val[0], 'h51);
            chk("t5_commit1", cm_val[1], 'h52);
        end
        chk("t5_nfetch", fv_cyc.size(), 0);

        // Reset mid-stream with a window counter at 3.
        idle(8);
        cyc(1, 1, 0, 'h61, 'h61, 0, a);
        idle(2);
        chk("t6_busy_pre", drain_busy_o[0], 1);
        rst_i = 1'b0;
        #1;
        chk("t6_level", level_o, 0);
        chk("t6_ready", in_ready_o, 1);
        chk("t6_busy", drain_busy_o, 0);
        chk("t6_fv", fetch_valid_o, 0);
        chk("t6_fch", fetch_ch_o, 0);
        chk("t6_fetch", fetch_o, 0);
        chk("t6_cv", commit_valid_o, 0);
        chk("t6_commit", commit_o, 0);
        @(posedge clk_i);
        #1;
        now++;
        rst_i = 1'b1;
        model_reset();
        clear_mon();
        idle(12);
        chk("t6_no_commit", cm_val.size(), 0);
        chk("t6_no_fetch", fv_cyc.size(), 0);

        // Randomized traffic against the model.
        repeat (400) begin
            cyc($urandom_range(9) < 7, 1'($urandom_range(1)),
                int'($urandom_range(1)), $urandom,
                COMMIT_W'($urandom), $urandom_range(19) == 0, a);
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_scheduler.md
# ctrl_scheduler

Parametrised successor to the single-queue control stage. It sits between the instruction decoder and the systolic array. Decoded operations are buffered in a small FIFO, and each drain operation is held back until the drain window of its target channel has expired; drain windows are tracked independently for N_CH array channels. Issued operations leave as a fetch stream one cycle after issue and as a commit stream COMMIT_LAT cycles after issue.

## Interface
Parameters:
- FETCH_W, 32: width of the fetch payload.
- COMMIT_W, 16: width of the commit payload.
- N_CH, 2: number of array channels; CH_W = max(1, $clog2(N_CH)).
- T_D, 4: drain window in cycles; must be at least 1.
- COMMIT_LAT, T_D+1: issue-to-commit latency in cycles; must be at least 1.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- STRICT, 0: when 1, non-drain operations also wait for their channel's drain window.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous and active-low.
- in_valid_i, in, 1: decoded operation valid.
- in_ready_o, out, 1: FIFO can accept an operation.
- in_drain_i, in, 1: operation requires a drain.
- in_ch_i, in, CH_W: target channel.
- in_fetch_i, in, FETCH_W: fetch payload.
- in_commit_i, in, COMMIT_W: commit payload.
- flush_i, in, 1: synchronous FIFO flush.
- fetch_valid_o, out, 1: fetch stream valid.
- fetch_ch_o, out, CH_W: fetch stream channel.
- fetch_o, out, FETCH_W: fetch stream payload.
- commit_valid_o, out, 1: commit stream valid.
- commit_o, out, COMMIT_W: commit stream payload.
- drain_busy_o, out, N_CH: bit i is (cnt[i] != 0).
- level_o, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO:
  - in_ready_o = (level != DEPTH) && !flush_i.
  - A push occurs when in_valid_i && in_ready_o.
  - A pushed entry can issue no earlier than the next cycle. There is no bypass.
- Issue condition: the FIFO is not empty, and blocked is false for the head entry.
  - blocked = (head.drain || STRICT) && cnt[head.ch] != 0.
  - Issuing pops the head entry.
  - At most one issue per cycle.
  - A blocked head stalls every entry behind it (in-order issue).
- Drain counters cnt[0..N_CH-1], each with range 0..T_D:
  - Each nonzero counter decrements by 1 per cycle and saturates at 0.
  - When a drain operation issues on channel c, cnt[c] is loaded with T_D on the next edge. The load overrides the decrement.
  - A drain operation that is stalled does not load its counter.
  - Channels are independent: a drain on channel 0 never blocks channel 1.
- Fetch output:
  - fetch_valid_o, fetch_ch_o and fetch_o are registered from the issuing entry.
  - fetch_valid_o is 0 in cycles with no issue.
- Commit output:
  - A COMMIT_LAT-stage shift pipe carries {valid, commit}.
  - Stage 0 is loaded at issue; commit_o comes from the last stage.
  - The pipe advances every cycle and is never stalled.
- flush_i:
  - On the next edge, level becomes 0 and head/tail pointers reset.
  - A push in the same cycle is refused (in_ready_o is low).
  - No issue occurs in a flush cycle.
  - Counters, the fetch register and the commit pipe are unaffected, so in-flight commits still emerge.
- Simultaneous push and pop when level == DEPTH-1 or below: level is unchanged and both operations take effect.
- When full, a push is refused even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- While rst_i is low, and after its release:
  - level_o = 0, in_ready_o = 1.
  - All counters are 0, so drain_busy_o = 0.
  - fetch_valid_o, fetch_ch_o and fetch_o are 0.
  - All commit pipe stages are 0, so commit_valid_o = 0 and commit_o = 0.
- Reset asserted mid-operation clears all state immediately. Queued and in-flight operations are discarded with no output.
- Minimum latency, for an operation accepted in cycle t into an empty FIFO with its channel idle:
  - Issue in cycle t+1.
  - fetch_valid_o high in cycle t+2.
  - commit_valid_o high in cycle t+1+COMMIT_LAT.
- Back-to-back drains: a drain issued on channel c in cycle k allows the next drain on channel c to issue no earlier than cycle k+T_D+1.
- Sustained throughput is one operation per cycle when no operation is blocked.

## Test plan
- Reset, then release; push 4 non-drain ops, ch 0, fetch values 1..4. Required: fetch_valid_o high for 4 consecutive cycles starting 2 cycles after the first push; commit_o emits 1..4 starting at t+1+COMMIT_LAT; level_o peaks at 1.
- T_D=4, two drain ops on ch 0 back to back. Required: issues exactly 5 cycles apart; drain_busy_o[0] high for 4 cycles after the first issue; in_ready_o stays high.
- Drain on ch 0 followed by drain on ch 1. Required: issues on consecutive cycles and drain_busy_o = 2'b11 for one overlap window. Same stimulus with a drain on ch 0 followed by a non-drain op on ch 0: STRICT=0 gives consecutive issues; STRICT=1 delays the second op by T_D cycles.
- With the head blocked, push until full. Required: in_ready_o goes low at level_o=4; a push attempted while full and popping is refused; no entry is lost or duplicated.
- flush_i with 3 entries queued and 2 commits in flight. Required: level_o=0 the next cycle; the 2 in-flight commits still emerge; a push in the flush cycle is refused.
- Assert rst_i low mid-stream with a counter at 3. Required: all outputs 0 and drain_busy_o=0 immediately; no commit emerges after release.
